// File: rtl/pc_pkg.sv
// pc_pkg: shared types and helpers for the next-PC unit.
//   npc_sel_t        - next-PC source select, evaluated every cycle
//   PC_RESET_DEFAULT - default program-counter reset value
//   sext()           - sign-extend the low imm_w bits of a 64-bit word
package pc_pkg;

    typedef enum logic [2:0] {
        NPC_HOLD,
        NPC_RET,
        NPC_CALL,
        NPC_JMP,
        NPC_BR,
        NPC_SEQ
    } npc_sel_t;

    localparam int unsigned PC_RESET_DEFAULT = 0;

    // The caller zero-extends the raw field into 64 bits and truncates the
    // result back to its own width. Shifting the sign bit up to bit 63 and
    // arithmetic-shifting it back replicates bit imm_w-1 across the upper bits.
    function automatic logic [63:0] sext(input logic [63:0] raw, input int unsigned imm_w);
        return 64'($signed(raw << (64 - imm_w)) >>> (64 - imm_w));
    endfunction

endpackage

// File: rtl/pc_next_unit_ras.sv
// ras_stack: circular return-address stack.
//   clk, rst           - clock, asynchronous active-high reset
//   push, pop          - push push_data / pop the top entry (pop wins if both)
//   push_data [N-1:0]  - return address to store
//   top_data  [N-1:0]  - most recently pushed entry
//   empty, full        - registered decode of the entry count
//   overflow           - push while full (oldest entry is overwritten)
//   underflow          - pop while empty (no state change)
module ras_stack #(
    parameter int unsigned N         = 16,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [N-1:0] push_data,
    output logic [N-1:0] top_data,
    output logic         empty,
    output logic         full,
    output logic         overflow,
    output logic         underflow
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    logic [N-1:0]     mem [RAS_DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_dec;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             do_pop;
    logic             do_push;

    assign do_pop    = pop && !empty;
    assign do_push   = push && !pop;
    assign ptr_dec   = ptr - PTR_W'(1);
    assign top_data  = mem[ptr_dec];
    assign overflow  = do_push && full;
    assign underflow = pop && empty;

    // A push into a full stack wraps over the oldest slot, so count saturates.
    always_comb begin
        cnt_nxt = cnt;
        if (do_pop)
            cnt_nxt = cnt - CNT_W'(1);
        else if (do_push && !full)
            cnt_nxt = cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr   <= '0;
            cnt   <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
        end else begin
            cnt   <= cnt_nxt;
            empty <= (cnt_nxt == '0);
            full  <= (cnt_nxt == CNT_W'(RAS_DEPTH));
            if (do_pop)
                ptr <= ptr_dec;
            else if (do_push)
                ptr <= ptr + PTR_W'(1);
        end
    end

    // Contents are don't-care after reset, so storage has no reset term.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[ptr] <= push_data;
    end

endmodule

// File: rtl/pc_next_unit.sv
// pc_next_unit: program-counter register with next-PC selection.
//   Optional macro PC_NEXT_RAS_EN builds the return-address stack; without it
//   call acts as jump, ret acts as sequential and the RAS flags are constant.
//   clk, rst             - clock, asynchronous active-high reset
//   stall                - hold PC and RAS
//   branch_taken, imm    - relative branch to Branch_target
//   jump, jump_target    - absolute jump
//   call / ret           - push PC_plus_one and jump / pop into PC
//   PC_out               - registered PC
//   PC_plus_one          - PC_out + 1 (combinational)
//   Branch_target        - PC_plus_one + sext(imm) (combinational)
//   ras_empty, ras_full  - RAS occupancy flags
//   ras_err              - sticky overflow/underflow flag
module pc_next_unit
    import pc_pkg::*;
#(
    parameter int unsigned N         = 16,
    parameter int unsigned IMM_W     = 8,
    parameter int unsigned RAS_DEPTH = 4,
    parameter int unsigned RESET_PC  = PC_RESET_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic             jump,
    input  logic             call,
    input  logic             ret,
    input  logic [IMM_W-1:0] imm,
    input  logic [N-1:0]     jump_target,
    output logic [N-1:0]     PC_out,
    output logic [N-1:0]     PC_plus_one,
    output logic [N-1:0]     Branch_target,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_err
);

    npc_sel_t     sel;
    logic [N-1:0] pc_q;
    logic [N-1:0] pc_nxt;
    logic [N-1:0] imm_sx;

    assign imm_sx        = N'(sext(64'(imm), IMM_W));
    assign PC_out        = pc_q;
    assign PC_plus_one   = pc_q + N'(1);
    assign Branch_target = PC_plus_one + imm_sx;

    always_comb begin
        sel = NPC_SEQ;
        if (stall)
            sel = NPC_HOLD;
        else if (ret)
            sel = NPC_RET;
        else if (call)
            sel = NPC_CALL;
        else if (jump)
            sel = NPC_JMP;
        else if (branch_taken)
            sel = NPC_BR;
    end

`ifdef PC_NEXT_RAS_EN
    logic [N-1:0] ras_top;
    logic         ras_ovf;
    logic         ras_unf;

    ras_stack #(
        .N         (N),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (sel == NPC_CALL),
        .pop       (sel == NPC_RET),
        .push_data (PC_plus_one),
        .top_data  (ras_top),
        .empty     (ras_empty),
        .full      (ras_full),
        .overflow  (ras_ovf),
        .underflow (ras_unf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ras_err <= 1'b0;
        else if (ras_ovf || ras_unf)
            ras_err <= 1'b1;
    end
`else
    logic [N-1:0] ras_top;

    // Without a stack a return simply falls through to the next instruction.
    assign ras_top   = PC_plus_one;
    assign ras_empty = 1'b1;
    assign ras_full  = 1'b0;
    assign ras_err   = 1'b0;
`endif

    always_comb begin
        pc_nxt = pc_q;
        case (sel)
            NPC_HOLD: pc_nxt = pc_q;
            NPC_RET:  pc_nxt = ras_empty ? PC_plus_one : ras_top;
            NPC_CALL: pc_nxt = jump_target;
            NPC_JMP:  pc_nxt = jump_target;
            NPC_BR:   pc_nxt = Branch_target;
            NPC_SEQ:  pc_nxt = PC_plus_one;
            default:  pc_nxt = pc_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pc_q <= N'(RESET_PC);
        else
            pc_q <= pc_nxt;
    end

endmodule

// File: tb/tb_pc_next_unit.sv
module tb_pc_next_unit;

    localparam int unsigned N     = 16;
    localparam int unsigned IMM_W = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned MASK  = 32'h0000_FFFF;
`ifdef PC_NEXT_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             stall, branch_taken, jump, call, ret;
    logic [IMM_W-1:0] imm;
    logic [N-1:0]     jump_target;
    logic [N-1:0]     PC_out, PC_plus_one, Branch_target;
    logic             ras_empty, ras_full, ras_err;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: PC value, stack as a queue (back = newest), sticky error.
    int unsigned m_pc;
    int unsigned m_stk[$];
    bit          m_err;

    pc_next_unit #(
        .N         (N),
        .IMM_W     (IMM_W),
        .RAS_DEPTH (DEPTH),
        .RESET_PC  (0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .jump          (jump),
        .call          (call),
        .ret           (ret),
        .imm           (imm),
        .jump_target   (jump_target),
        .PC_out        (PC_out),
        .PC_plus_one   (PC_plus_one),
        .Branch_target (Branch_target),
        .ras_empty     (ras_empty),
        .ras_full      (ras_full),
        .ras_err       (ras_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic int unsigned m_pp();
        return (m_pc + 1) & MASK;
    endfunction

    function automatic int unsigned m_bt(input logic [IMM_W-1:0] i);
        int s;
        s = int'($signed(i));
        return (m_pp() + int'(s)) & MASK;
    endfunction

    function automatic void model_reset();
        m_pc  = 0;
        m_stk.delete();
        m_err = 1'b0;
    endfunction

    // Applies one clock edge of the next-PC rules to the model.
    function automatic void model_edge();
        int unsigned pp;
        pp = m_pp();
        if (stall) begin
            // nothing changes
        end else if (ret) begin
            if (RAS_EN && m_stk.size() > 0) begin
                m_pc = m_stk.pop_back();
            end else begin
                if (RAS_EN) m_err = 1'b1;
                m_pc = pp;
            end
        end else if (call) begin
            if (RAS_EN) begin
                if (m_stk.size() == DEPTH) begin
                    void'(m_stk.pop_front());
                    m_err = 1'b1;
                end
                m_stk.push_back(pp);
            end
            m_pc = int'(jump_target);
        end else if (jump) begin
            m_pc = int'(jump_target);
        end else if (branch_taken) begin
            m_pc = m_bt(imm);
        end else begin
            m_pc = pp;
        end
    endfunction

    task automatic drive(input logic s, input logic b, input logic j, input logic c,
                         input logic r, input logic [IMM_W-1:0] i, input logic [N-1:0] t);
        stall = s; branch_taken = b; jump = j; call = c; ret = r;
        imm = i; jump_target = t;
    endtask

    // Called at posedge+1 with inputs already driven; leaves time at posedge+1.
    task automatic step(input string tag);
        #1;
        chk({tag, "_pp"}, 32'(PC_plus_one), m_pp());
        chk({tag, "_bt"}, 32'(Branch_target), m_bt(imm));
        model_edge();
        @(posedge clk);
        #1;
        chk({tag, "_pc"}, 32'(PC_out), m_pc);
        chk({tag, "_empty"}, 32'(ras_empty), 32'(!RAS_EN || m_stk.size() == 0));
        chk({tag, "_full"}, 32'(ras_full), 32'(RAS_EN && m_stk.size() == DEPTH));
        chk({tag, "_err"}, 32'(ras_err), 32'(m_err));
    endtask

    // Asserts reset away from the clock edge and checks it takes effect at once.
    task automatic do_reset_mid();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("async_rst_pc", 32'(PC_out), 0);
        chk("async_rst_empty", 32'(ras_empty), 1);
        chk("async_rst_full", 32'(ras_full), 0);
        chk("async_rst_err", 32'(ras_err), 0);
        @(posedge clk);
        #1;
        chk("rst_hold_pc", 32'(PC_out), 0);
        rst = 1'b0;
    endtask

    typedef struct {
        logic             s, b, j, c, r;
        logic [IMM_W-1:0] i;
        logic [N-1:0]     t;
        logic [N-1:0]     exp_pp;
        logic [N-1:0]     exp_bt;
        logic [N-1:0]     exp_pc;
    } vec_t;

    vec_t vecs[9];

    initial begin
        // stall branch jump call ret imm jt | PC_plus_one Branch_target next PC
        vecs[0] = '{0, 1, 0, 0, 0, 8'hF6, 16'h0000, 16'h0004, 16'hFFFA, 16'hFFFA};
        vecs[1] = '{0, 0, 1, 0, 0, 8'h00, 16'hFFFF, 16'hFFFB, 16'hFFFB, 16'hFFFF};
        vecs[2] = '{0, 0, 0, 0, 0, 8'h05, 16'h1234, 16'h0000, 16'h0005, 16'h0000};
        vecs[3] = '{0, 0, 1, 0, 0, 8'h00, 16'h000A, 16'h0001, 16'h0001, 16'h000A};
        vecs[4] = '{0, 1, 0, 0, 0, 8'h14, 16'h0000, 16'h000B, 16'h001F, 16'h001F};
        vecs[5] = '{1, 1, 1, 0, 0, 8'h01, 16'h0500, 16'h0020, 16'h0021, 16'h001F};
        vecs[6] = '{0, 1, 1, 0, 0, 8'h7F, 16'h0040, 16'h0020, 16'h009F, 16'h0040};
        vecs[7] = '{0, 1, 0, 0, 0, 8'h80, 16'h0000, 16'h0041, 16'hFFC1, 16'hFFC1};
        vecs[8] = '{0, 0, 0, 0, 0, 8'h00, 16'h0000, 16'hFFC2, 16'hFFC2, 16'hFFC2};

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, '0, '0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("pre0");
        step("pre1");

        // Reset mid-stream, then plain sequential fetch 0 -> 1 -> 2 -> 3.
        do_reset_mid();
        for (int k = 1; k <= 3; k++) begin
            step("seq");
            chk("seq_const_pc", 32'(PC_out), 32'(k));
        end

        // Arithmetic/priority table, starts from PC = 3.
        for (int v = 0; v < 9; v++) begin
            drive(vecs[v].s, vecs[v].b, vecs[v].j, vecs[v].c, vecs[v].r, vecs[v].i, vecs[v].t);
            #1;
            chk($sformatf("vec%0d_pp", v), 32'(PC_plus_one), 32'(vecs[v].exp_pp));
            chk($sformatf("vec%0d_bt", v), 32'(Branch_target), 32'(vecs[v].exp_bt));
            model_edge();
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_pc", v), 32'(PC_out), 32'(vecs[v].exp_pc));
            chk($sformatf("vec%0d_empty", v), 32'(ras_empty), 1);
        end

        // Nested call/return.
        do_reset_mid();
        drive(0, 0, 1, 0, 0, '0, 16'h0005); step("nest_j");
        drive(0, 0, 0, 1, 0, '0, 16'h0100); step("nest_c1");
        drive(0, 0, 0, 1, 0, '0, 16'h0200); step("nest_c2");
        chk("nest_pc_c2", 32'(PC_out), 32'h200);
        drive(0, 0, 0, 0, 1, '0, '0); step("nest_r1");
        chk("nest_pc_r1", 32'(PC_out), RAS_EN ? 32'h101 : 32'h201);
        step("nest_r2");
        chk("nest_pc_r2", 32'(PC_out), RAS_EN ? 32'h006 : 32'h202);
        chk("nest_empty", 32'(ras_empty), 1);
        chk("nest_err", 32'(ras_err), 0);

        // Overflow by five calls, then drain with five returns.
        do_reset_mid();
        for (int k = 1; k <= 5; k++) begin
            drive(0, 0, 0, 1, 0, '0, 16'(k * 16));
            step("ovf_call");
            if (k == 4) chk("full_after_4", 32'(ras_full), 32'(RAS_EN));
        end
        chk("err_after_5", 32'(ras_err), 32'(RAS_EN));
        begin
            logic [N-1:0] exp_ret[5];
            exp_ret = RAS_EN ? '{16'h41, 16'h31, 16'h21, 16'h11, 16'h12}
                             : '{16'h51, 16'h52, 16'h53, 16'h54, 16'h55};
            for (int k = 0; k < 5; k++) begin
                drive(0, 0, 0, 0, 1, '0, '0);
                step("drain_ret");
                chk($sformatf("drain_pc%0d", k), 32'(PC_out), 32'(exp_ret[k]));
            end
        end
        chk("err_sticky", 32'(ras_err), 32'(RAS_EN));

        // Stall overrides everything.
        drive(1, 1, 0, 1, 0, 8'h10, 16'h0777); step("stall");
        chk("stall_pc", 32'(PC_out), RAS_EN ? 32'h12 : 32'h55);

        // ret+call+jump with one stacked entry: pop only.
        do_reset_mid();
        drive(0, 0, 0, 1, 0, '0, 16'h0300); step("pri_call");
        drive(0, 0, 1, 1, 1, '0, 16'h0700); step("pri_rcj");
        chk("pri_pc", 32'(PC_out), RAS_EN ? 32'h001 : 32'h301);
        chk("pri_empty", 32'(ras_empty), 1);

        // Randomized run against the model.
        for (int n = 0; n < 400; n++) begin
            if (n % 97 == 96) begin
                do_reset_mid();
            end else begin
                drive($urandom_range(7) == 0, $urandom_range(2) == 0, $urandom_range(7) == 0,
                      $urandom_range(4) == 0, $urandom_range(4) == 0,
                      IMM_W'($urandom), N'($urandom));
                step("rnd");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
